flag_intr_unit: RTL and testbench

FLAG_INTR_UNIT -- requirements
Module: flag_intr_unit

---
 rtl/flag_intr_unit.sv | 123 ++++++++++++
 tb/tb_flag_intr_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_intr_unit.sv
// Carry/zero/interrupt-enable flags plus a synchronized interrupt front end and service FSM.
// Interrupt line to INT_REQ takes SYNC_STAGES+1 edges; INT_REQ/SHAD_LD are combinational from state.
module flag_intr_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_RESTORE,
  input  logic SHAD_C_IN,
  input  logic SHAD_Z_IN,
  input  logic INT_SET,
  input  logic INT_CLR,
  input  logic INT_IN,
  input  logic INT_ACK,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic SHAD_LD,
  output logic I_FLAG,
  output logic INT_REQ,
  output logic IN_SVC
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PEND     = 2'd1;
  localparam logic [1:0] ST_SVC      = 2'd2;
  localparam logic [1:0] ST_SVC_PEND = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   int_event;
  logic                   ack_acc;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic                   c_nxt;
  logic                   z_nxt;
  logic                   i_nxt;

  // Sync chain shifts toward the MSB; edge_q holds the previous synchronized level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], INT_IN};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign int_event = sync_q[SYNC_STAGES-1] & ~edge_q;

  assign INT_REQ = (state == ST_PEND) & I_FLAG;
  assign ack_acc = INT_ACK & INT_REQ;
  assign SHAD_LD = ack_acc;
  assign IN_SVC  = (state == ST_SVC) | (state == ST_SVC_PEND);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (int_event) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        // An event arriving with the ack is parked behind the new handler.
        if (ack_acc) state_nxt = int_event ? ST_SVC_PEND : ST_SVC;
      end
      ST_SVC: begin
        if (int_event && FLG_RESTORE) state_nxt = ST_PEND;
        else if (int_event)           state_nxt = ST_SVC_PEND;
        else if (FLG_RESTORE)         state_nxt = ST_IDLE;
      end
      ST_SVC_PEND: begin
        if (FLG_RESTORE) state_nxt = ST_PEND;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    c_nxt = C_FLAG;
    if (FLG_RESTORE)    c_nxt = SHAD_C_IN;
    else if (FLG_C_CLR) c_nxt = 1'b0;
    else if (FLG_C_SET) c_nxt = 1'b1;
    else if (FLG_C_LD)  c_nxt = ALU_C;

    z_nxt = Z_FLAG;
    if (FLG_RESTORE)   z_nxt = SHAD_Z_IN;
    else if (FLG_Z_LD) z_nxt = ALU_Z;

    i_nxt = I_FLAG;
    if (ack_acc)          i_nxt = 1'b0;
    else if (FLG_RESTORE) i_nxt = 1'b1;
    else if (INT_CLR)     i_nxt = 1'b0;
    else if (INT_SET)     i_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      C_FLAG <= 1'b0;
      Z_FLAG <= 1'b0;
      I_FLAG <= 1'b0;
    end else begin
      state  <= state_nxt;
      C_FLAG <= c_nxt;
      Z_FLAG <= z_nxt;
      I_FLAG <= i_nxt;
    end
  end

  // Entering service always masks further requests until RETIE.
  a_ack_enters_svc: assert property (@(posedge CLK) disable iff (!RST_N)
    SHAD_LD |=> (!I_FLAG && IN_SVC));

  a_req_only_pend: assert property (@(posedge CLK) disable iff (!RST_N)
    INT_REQ |-> (state == ST_PEND));

endmodule

// File: tb/tb_flag_intr_unit.sv
// Randomized and directed bench for flag_intr_unit with a queue-based scoreboard.
module tb_flag_intr_unit;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic alu_c, alu_z, c_ld, z_ld, c_set, c_clr, restore, shad_c, shad_z;
  logic i_set, i_clr, int_in, ack;
  logic c_flag, z_flag, shad_ld, i_flag, int_req, in_svc;

  typedef struct packed {
    logic alu_c, alu_z, c_ld, z_ld, c_set, c_clr, restore, shad_c, shad_z;
    logic i_set, i_clr, int_in, ack;
  } stim_t;

  typedef struct {
    logic [5:0] v;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  bit   m_c, m_z, m_i, m_pend, m_svc;
  stim_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  flag_intr_unit #(.SYNC_STAGES(S)) dut (
    .CLK(clk), .RST_N(rst_n), .ALU_C(alu_c), .ALU_Z(alu_z),
    .FLG_C_LD(c_ld), .FLG_Z_LD(z_ld), .FLG_C_SET(c_set), .FLG_C_CLR(c_clr),
    .FLG_RESTORE(restore), .SHAD_C_IN(shad_c), .SHAD_Z_IN(shad_z),
    .INT_SET(i_set), .INT_CLR(i_clr), .INT_IN(int_in), .INT_ACK(ack),
    .C_FLAG(c_flag), .Z_FLAG(z_flag), .SHAD_LD(shad_ld), .I_FLAG(i_flag),
    .INT_REQ(int_req), .IN_SVC(in_svc)
  );

  always #5 clk = ~clk;

  task automatic drive(input stim_t v);
    cur = v;
    {alu_c, alu_z, c_ld, z_ld, c_set, c_clr, restore, shad_c, shad_z,
     i_set, i_clr, int_in, ack} = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit samp(int back);
    int idx = hist.size() - back;
    if (idx < 0) return 1'b0;
    return hist[idx];
  endfunction

  function automatic stim_t nop();
    stim_t s = '0;
    s.int_in = cur.int_in;
    return s;
  endfunction

  task automatic model_reset();
    m_c = 0; m_z = 0; m_i = 0; m_pend = 0; m_svc = 0;
    hist.delete();
  endtask

  // One clock cycle: predict this cycle's outputs, then advance the model at the edge.
  task automatic step(input stim_t v);
    bit req, shd, ev, acc;
    exp_t e;
    drive(v);
    req = m_pend & ~m_svc & m_i;
    shd = v.ack & req;
    e.v = {m_c, m_z, shd, m_i, req, m_svc};
    e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    cyc++;
    ev  = samp(S) & ~samp(S + 1);
    hist.push_back(v.int_in);
    if (hist.size() > 8) void'(hist.pop_front());
    acc = shd;
    if (v.restore)    m_c = v.shad_c;
    else if (v.c_clr) m_c = 0;
    else if (v.c_set) m_c = 1;
    else if (v.c_ld)  m_c = v.alu_c;
    if (v.restore)    m_z = v.shad_z;
    else if (v.z_ld)  m_z = v.alu_z;
    if (acc)            m_i = 0;
    else if (v.restore) m_i = 1;
    else if (v.i_clr)   m_i = 0;
    else if (v.i_set)   m_i = 1;
    if (acc) begin
      m_svc  = 1;
      m_pend = ev;
    end else begin
      if (v.restore && m_svc) m_svc = 0;
      if (ev) m_pend = 1;
    end
    if (!m_svc && acc == 0 && !ev && v.restore && !m_pend) m_pend = 0;
    #1;
  endtask

  task automatic raise_event();
    stim_t s = nop();
    s.int_in = 0;
    repeat (S + 2) step(s);
    s.int_in = 1;
    repeat (S + 2) step(s);
  endtask

  task automatic async_reset(input string name);
    stim_t s = '0;
    #2;
    s.ack = 1;
    s.int_in = cur.int_in;
    drive(s);
    rst_n = 0;
    #1;
    check({name, "_outs"}, {c_flag, z_flag, shad_ld, i_flag, int_req, in_svc}, 6'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    drive(nop());
  endtask

  // Monitor: every cycle the DUT presents one output vector for the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {c_flag, z_flag, shad_ld, i_flag, int_req, in_svc};
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL outputs{C,Z,SHAD_LD,I,REQ,SVC} cycle %0d: got %b expected %b", e.cyc, act, e.v);
      end
    end
  end

  initial begin
    stim_t s;
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    stim_t s;
    int n;
    rst_n = 0;
    drive('0);
    ack = 1;
    model_reset();
    #3;
    check("reset_outs", {c_flag, z_flag, shad_ld, i_flag, int_req, in_svc}, 6'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    drive('0);
    step(nop());

    // Carry priority: clear beats set beats load.
    s = nop(); s.c_set = 1; s.c_clr = 1; s.c_ld = 1; s.alu_c = 1;
    step(s);
    check("c_clr_wins", c_flag, 1'b0);
    s = nop(); s.c_set = 1; s.c_ld = 1; s.alu_c = 0;
    step(s);
    check("c_set_wins", c_flag, 1'b1);

    // Latency from a clean rising edge to INT_REQ, then a long high level.
    s = nop(); s.i_set = 1;
    step(s);
    s = nop(); s.int_in = 1;
    n = 0;
    do begin
      step(s);
      n++;
    end while (!int_req && n < 10);
    check("req_latency", n, S + 1);
    repeat (20) step(nop());
    s = nop(); s.ack = 1;
    step(s);
    repeat (5) step(nop());
    check("single_event_svc", in_svc, 1'b1);
    s = nop(); s.restore = 1; s.shad_c = 1; s.shad_z = 0;
    step(s);
    step(nop());
    check("single_event_idle", int_req, 1'b0);

    // Entry and exit with shadowed flags.
    s = nop(); s.c_ld = 1; s.alu_c = 1; s.z_ld = 1; s.alu_z = 1;
    step(s);
    raise_event();
    s = nop(); s.ack = 1;
    drive(s);
    #1;
    check("shad_ld_on_ack", shad_ld, 1'b1);
    #(-0);
    step(s);
    check("ack_masks_i", i_flag, 1'b0);
    s = nop(); s.c_ld = 1; s.alu_c = 0; s.z_ld = 1; s.alu_z = 0;
    step(s);
    s = nop(); s.restore = 1; s.shad_c = 1; s.shad_z = 1;
    step(s);
    check("restore_flags", {c_flag, z_flag, i_flag, in_svc}, 4'b1110);

    // Masked event waits in PEND until the enable returns.
    s = nop(); s.i_clr = 1;
    step(s);
    raise_event();
    s = nop(); s.ack = 1;
    step(s);
    check("masked_no_svc", in_svc, 1'b0);
    s = nop(); s.i_set = 1;
    step(s);
    check("unmask_req", int_req, 1'b1);
    s = nop(); s.ack = 1;
    step(s);

    // Event during service parks until RETIE.
    raise_event();
    check("svc_pend_no_req", {int_req, in_svc}, 2'b01);
    s = nop(); s.restore = 1;
    step(s);
    check("svc_pend_to_pend", int_req, 1'b1);
    s = nop(); s.ack = 1;
    step(s);
    s = nop(); s.c_set = 1;
    step(s);
    async_reset("reset_mid_svc");
    step(nop());
    check("post_reset_idle", {in_svc, int_req}, 2'b00);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 1200; i++) begin
      s = nop();
      if ($urandom_range(5) == 0) s.int_in = ~cur.int_in;
      s.alu_c   = 1'($urandom);
      s.alu_z   = 1'($urandom);
      s.c_ld    = ($urandom_range(3) == 0);
      s.z_ld    = ($urandom_range(3) == 0);
      s.c_set   = ($urandom_range(5) == 0);
      s.c_clr   = ($urandom_range(5) == 0);
      s.restore = ($urandom_range(7) == 0);
      s.shad_c  = 1'($urandom);
      s.shad_z  = 1'($urandom);
      s.i_set   = ($urandom_range(4) == 0);
      s.i_clr   = ($urandom_range(9) == 0);
      s.ack     = ($urandom_range(2) == 0);
      step(s);
      if (i == 600) async_reset("reset_random");
    end
    step(nop());
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
